// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths, register-file size and the writeback entry type used by the
// writeback queue, its storage sub-module, its interface and its bench.
package regfile_writeback_queue_pkg;

   localparam int DATA_W        = 32;
   localparam int REG_NUM_W     = 5;
   localparam int REG_FILE_SIZE = 1 << REG_NUM_W;
   localparam int DEPTH_DEF     = 4;

   // One pending register-file write: destination register and value.
   typedef struct packed {
      logic [REG_NUM_W-1:0] num;
      logic [DATA_W-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Bundle of the producer handshakes, the register-file write port, the two
// bypass lookup ports and the occupancy status of the writeback queue.
// slave = the queue itself, master = whoever drives producers / observes.
interface regfile_writeback_queue_if
   import regfile_writeback_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) ();

   logic                       alu_valid;
   logic                       alu_ready;
   logic [REG_NUM_W-1:0]       alu_num;
   logic [DATA_W-1:0]          alu_data;
   logic                       ld_valid;
   logic                       ld_ready;
   logic [REG_NUM_W-1:0]       ld_num;
   logic [DATA_W-1:0]          ld_data;
   logic                       wr_enable;
   logic [REG_NUM_W-1:0]       wr_num;
   logic [DATA_W-1:0]          wr_data;
   logic [REG_NUM_W-1:0]       byp_num_a;
   logic                       byp_hit_a;
   logic [DATA_W-1:0]          byp_data_a;
   logic [REG_NUM_W-1:0]       byp_num_b;
   logic                       byp_hit_b;
   logic [DATA_W-1:0]          byp_data_b;
   logic [$clog2(DEPTH)+1:0]   pending_cnt;
   logic                       empty;

   modport slave (
      input  alu_valid, alu_num, alu_data, ld_valid, ld_num, ld_data,
             byp_num_a, byp_num_b,
      output alu_ready, ld_ready, wr_enable, wr_num, wr_data,
             byp_hit_a, byp_data_a, byp_hit_b, byp_data_b, pending_cnt, empty
   );

   modport master (
      output alu_valid, alu_num, alu_data, ld_valid, ld_num, ld_data,
             byp_num_a, byp_num_b,
      input  alu_ready, ld_ready, wr_enable, wr_num, wr_data,
             byp_hit_a, byp_data_a, byp_hit_b, byp_data_b, pending_cnt, empty
   );

endinterface

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// In-order storage for accepted writebacks. Pointers wrap modulo DEPTH and the
// occupancy count is tracked separately, so full and empty are unambiguous.
// The per-slot visibility vector marks which physical slots hold live entries
// so the parent can run its bypass search without knowing the pointer scheme.
module regfile_writeback_queue_wb_fifo
   import regfile_writeback_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  wb_entry_t                  push_entry_i,
   input  logic                       pop_i,
   output wb_entry_t                  head_entry_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH)-1:0]   head_ptr_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output wb_entry_t [DEPTH-1:0]      slots_o,
   output logic [DEPTH-1:0]           vis_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Pointer and occupancy next-state; push and pop are independent.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) begin
         tail_d = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
      if (pop_i) begin
         head_d = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; a reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= {PTR_W{1'b0}};
         tail_q  <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless until marked visible, so no reset.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[tail_q] <= push_entry_i;
      end
   end

   // A slot is live when its distance from head is below the occupancy.
   always_comb begin
      vis_o = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         vis_o[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
      end
   end

   assign head_entry_o = mem_q[head_q];
   assign full_o       = (count_q == DEPTH_CNT);
   assign empty_o      = (count_q == {CNT_W{1'b0}});
   assign head_ptr_o   = head_q;
   assign count_o      = count_q;
   assign slots_o      = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the register file's single write port. ALU and
// load results are accepted one per cycle (ALU first), queued in order, and
// presented to the file through a one-cycle registered stage. Both read ports
// can look up values that are accepted but not yet captured by the file.
module regfile_writeback_queue
   import regfile_writeback_queue_pkg::*;
#(
   parameter int DEPTH         = DEPTH_DEF,
   parameter bit ZERO_REG_DROP = 1'b0
) (
   input logic                      clk,
   input logic                      rst_n,
   regfile_writeback_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } byp_t;

   logic                  full_s, fifo_empty_s;
   logic                  alu_acc_s, ld_acc_s, drop_s, push_s, pop_s;
   wb_entry_t             push_entry_s, head_entry_s;
   wb_entry_t [DEPTH-1:0] slots_s;
   logic [DEPTH-1:0]      vis_s;
   logic [PTR_W-1:0]      head_ptr_s;
   logic [CNT_W-1:0]      count_s;
   logic                  wr_enable_q, wr_enable_d;
   logic [REG_NUM_W-1:0]  wr_num_q, wr_num_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d;
   byp_t                  byp_a_s, byp_b_s;
   logic [CNT_W:0]        pending_cnt_s;

   // Youngest pending value for num. The output stage is the oldest candidate,
   // then queued entries oldest to youngest, each later match overriding.
   function automatic byp_t byp_lookup(input logic [REG_NUM_W-1:0] num);
      byp_t             r;
      logic [PTR_W-1:0] idx;
      logic             match;
      r.hit  = wr_enable_q && (wr_num_q == num);
      r.data = r.hit ? wr_data_q : {DATA_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         idx    = head_ptr_s + PTR_W'(k);
         match  = vis_s[idx] && (slots_s[idx].num == num);
         r.hit  = r.hit | match;
         r.data = match ? slots_s[idx].data : r.data;
      end
      return r;
   endfunction

   // Arbitration: ALU has fixed priority; r0 writes may be swallowed after the handshake.
   always_comb begin
      alu_acc_s = bus.alu_valid && !full_s;
      ld_acc_s  = bus.ld_valid && !bus.alu_valid && !full_s;
      if (bus.alu_valid) begin
         push_entry_s.num  = bus.alu_num;
         push_entry_s.data = bus.alu_data;
      end else begin
         push_entry_s.num  = bus.ld_num;
         push_entry_s.data = bus.ld_data;
      end
      drop_s = ZERO_REG_DROP && (push_entry_s.num == {REG_NUM_W{1'b0}});
      push_s = (alu_acc_s || ld_acc_s) && !drop_s;
      pop_s  = !fifo_empty_s;
   end

   regfile_writeback_queue_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push_s),
      .push_entry_i (push_entry_s),
      .pop_i        (pop_s),
      .head_entry_o (head_entry_s),
      .full_o       (full_s),
      .empty_o      (fifo_empty_s),
      .head_ptr_o   (head_ptr_s),
      .count_o      (count_s),
      .slots_o      (slots_s),
      .vis_o        (vis_s)
   );

   // Output stage next-state: load the head whenever one exists, else idle and hold.
   always_comb begin
      wr_enable_d = 1'b0;
      wr_num_d    = wr_num_q;
      wr_data_d   = wr_data_q;
      if (pop_s) begin
         wr_enable_d = 1'b1;
         wr_num_d    = head_entry_s.num;
         wr_data_d   = head_entry_s.data;
      end else begin
         wr_enable_d = 1'b0;
      end
   end

   // Output stage register; reset kills any in-flight write immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_enable_q <= 1'b0;
         wr_num_q    <= {REG_NUM_W{1'b0}};
         wr_data_q   <= {DATA_W{1'b0}};
      end else begin
         wr_enable_q <= wr_enable_d;
         wr_num_q    <= wr_num_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Bypass lookups for both read ports.
   always_comb begin
      byp_a_s = byp_lookup(bus.byp_num_a);
      byp_b_s = byp_lookup(bus.byp_num_b);
   end

   assign pending_cnt_s  = {1'b0, count_s} + {{CNT_W{1'b0}}, wr_enable_q};

   assign bus.alu_ready   = !full_s;
   assign bus.ld_ready    = !full_s && !bus.alu_valid;
   assign bus.wr_enable   = wr_enable_q;
   assign bus.wr_num      = wr_num_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.byp_hit_a   = byp_a_s.hit;
   assign bus.byp_data_a  = byp_a_s.data;
   assign bus.byp_hit_b   = byp_b_s.hit;
   assign bus.byp_data_b  = byp_b_s.data;
   assign bus.pending_cnt = pending_cnt_s;
   assign bus.empty       = (pending_cnt_s == {(CNT_W+1){1'b0}});

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for the writeback queue. dut0 uses the default configuration and is
// tracked by a queue-based reference model; dut1 drops r0 writes and is only
// exercised by the zero-register scenario.
module tb_regfile_writeback_queue;
   import regfile_writeback_queue_pkg::*;

   localparam int DEPTH = DEPTH_DEF;
   localparam int PC_W  = $clog2(DEPTH) + 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus0 ();
   regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus1 ();

   regfile_writeback_queue #(.DEPTH(DEPTH), .ZERO_REG_DROP(1'b0)) dut0 (
      .clk (clk), .rst_n (rst_n), .bus (bus0)
   );

   regfile_writeback_queue #(.DEPTH(DEPTH), .ZERO_REG_DROP(1'b1)) dut1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: results accepted but not yet presented, in acceptance
   // order, plus the one write currently presented to the register file.
   wb_entry_t            m_fifo[$];
   logic                 m_wen;
   logic [REG_NUM_W-1:0] m_wnum;
   logic [DATA_W-1:0]    m_wdata;
   logic                 m_acc_alu;
   logic                 m_acc_ld;

   task automatic model_reset();
      m_fifo.delete();
      m_wen   = 1'b0;
      m_wnum  = '0;
      m_wdata = '0;
   endtask

   // Youngest pending value for register n, searching newest acceptance first.
   function automatic void m_byp(input logic [REG_NUM_W-1:0] n,
                                 output logic hit, output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      for (int i = m_fifo.size() - 1; i >= 0; i--) begin
         if (!hit && m_fifo[i].num == n) begin
            hit = 1'b1;
            d   = m_fifo[i].data;
         end
      end
      if (!hit && m_wen && m_wnum == n) begin
         hit = 1'b1;
         d   = m_wdata;
      end
   endfunction

   task automatic idle_inputs();
      bus0.alu_valid = 1'b0; bus0.alu_num = '0; bus0.alu_data = '0;
      bus0.ld_valid  = 1'b0; bus0.ld_num  = '0; bus0.ld_data  = '0;
      bus0.byp_num_a = '0;   bus0.byp_num_b = '0;
      bus1.alu_valid = 1'b0; bus1.alu_num = '0; bus1.alu_data = '0;
      bus1.ld_valid  = 1'b0; bus1.ld_num  = '0; bus1.ld_data  = '0;
      bus1.byp_num_a = '0;   bus1.byp_num_b = '0;
   endtask

   // One clock edge for dut0 with the current inputs, advancing the model.
   task automatic tick();
      logic      room;
      wb_entry_t e;
      room      = (m_fifo.size() < DEPTH);
      m_acc_alu = rst_n && bus0.alu_valid && room;
      m_acc_ld  = rst_n && bus0.ld_valid && !bus0.alu_valid && room;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_fifo.size() != 0) begin
            e       = m_fifo.pop_front();
            m_wen   = 1'b1;
            m_wnum  = e.num;
            m_wdata = e.data;
         end else begin
            m_wen = 1'b0;
         end
         if (m_acc_alu) begin
            e.num = bus0.alu_num; e.data = bus0.alu_data; m_fifo.push_back(e);
         end else if (m_acc_ld) begin
            e.num = bus0.ld_num;  e.data = bus0.ld_data;  m_fifo.push_back(e);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (bus0.wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_enable: got %0b want 0", bus0.wr_enable); end
      checks++; if (bus0.wr_num !== 5'd0) begin errors++; $display("FAIL reset_wr_num: got %0d want 0", bus0.wr_num); end
      checks++; if (bus0.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %0h want 0", bus0.wr_data); end
      checks++; if (bus0.pending_cnt !== PC_W'(0)) begin errors++; $display("FAIL reset_pending: got %0d want 0", bus0.pending_cnt); end
      checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", bus0.empty); end
      checks++; if (bus0.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %0b want 1", bus0.alu_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_alu();
      bus0.alu_valid = 1'b1; bus0.alu_num = 5'd5; bus0.alu_data = 32'h1234;
      #1;
      checks++; if (bus0.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", bus0.alu_ready); end
      tick();
      bus0.alu_valid = 1'b0;
      #1;
      checks++; if (bus0.wr_enable !== 1'b0) begin errors++; $display("FAIL single_early: got %0b want 0", bus0.wr_enable); end
      checks++; if (bus0.pending_cnt !== PC_W'(1)) begin errors++; $display("FAIL single_pend1: got %0d want 1", bus0.pending_cnt); end
      checks++; if (bus0.empty !== 1'b0) begin errors++; $display("FAIL single_nonempty: got %0b want 0", bus0.empty); end
      tick();
      checks++; if ({bus0.wr_enable, bus0.wr_num, bus0.wr_data} !== {1'b1, 5'd5, 32'h1234})
         begin errors++; $display("FAIL single_write: got en=%0b num=%0d data=%0h want en=1 num=5 data=1234", bus0.wr_enable, bus0.wr_num, bus0.wr_data); end
      checks++; if (bus0.pending_cnt !== PC_W'(1)) begin errors++; $display("FAIL single_pend_stage: got %0d want 1", bus0.pending_cnt); end
      tick();
      checks++; if (bus0.wr_enable !== 1'b0) begin errors++; $display("FAIL single_pulse_len: got %0b want 0", bus0.wr_enable); end
      checks++; if (bus0.wr_num !== 5'd5) begin errors++; $display("FAIL single_hold_num: got %0d want 5", bus0.wr_num); end
      checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0b want 1", bus0.empty); end
   endtask

   task automatic test_alu_ld_priority();
      bus0.byp_num_a = 5'd3;
      bus0.alu_valid = 1'b1; bus0.alu_num = 5'd3; bus0.alu_data = 32'hA;
      bus0.ld_valid  = 1'b1; bus0.ld_num  = 5'd3; bus0.ld_data  = 32'hB;
      #1;
      checks++; if (bus0.alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready: got %0b want 1", bus0.alu_ready); end
      checks++; if (bus0.ld_ready !== 1'b0) begin errors++; $display("FAIL prio_ld_blocked: got %0b want 0", bus0.ld_ready); end
      checks++; if (bus0.byp_hit_a !== 1'b0) begin errors++; $display("FAIL prio_no_early_hit: got %0b want 0", bus0.byp_hit_a); end
      tick();
      bus0.alu_valid = 1'b0;
      #1;
      checks++; if (bus0.ld_ready !== 1'b1) begin errors++; $display("FAIL prio_ld_ready: got %0b want 1", bus0.ld_ready); end
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b1, 32'hA}) begin errors++; $display("FAIL prio_byp_a: got hit=%0b data=%0h want hit=1 data=a", bus0.byp_hit_a, bus0.byp_data_a); end
      tick();
      bus0.ld_valid = 1'b0;
      #1;
      checks++; if ({bus0.wr_enable, bus0.wr_num, bus0.wr_data} !== {1'b1, 5'd3, 32'hA}) begin errors++; $display("FAIL prio_first_write: got en=%0b data=%0h want en=1 data=a", bus0.wr_enable, bus0.wr_data); end
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b1, 32'hB}) begin errors++; $display("FAIL prio_byp_young: got hit=%0b data=%0h want hit=1 data=b", bus0.byp_hit_a, bus0.byp_data_a); end
      tick();
      checks++; if ({bus0.wr_enable, bus0.wr_data} !== {1'b1, 32'hB}) begin errors++; $display("FAIL prio_second_write: got en=%0b data=%0h want en=1 data=b", bus0.wr_enable, bus0.wr_data); end
      tick();
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b0, 32'h0}) begin errors++; $display("FAIL prio_byp_clear: got hit=%0b data=%0h want hit=0 data=0", bus0.byp_hit_a, bus0.byp_data_a); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] sent[$];
      logic [DATA_W-1:0] got[$];
      for (int i = 0; i < 10; i++) begin
         bus0.alu_valid = (i % 2 == 0);
         bus0.ld_valid  = (i % 2 != 0);
         bus0.alu_num   = REG_NUM_W'(i + 1);
         bus0.ld_num    = REG_NUM_W'(i + 1);
         bus0.alu_data  = $urandom;
         bus0.ld_data   = $urandom;
         sent.push_back((i % 2 == 0) ? bus0.alu_data : bus0.ld_data);
         #1;
         checks++; if ((bus0.alu_ready && (bus0.ld_ready || bus0.alu_valid)) !== 1'b1)
            begin errors++; $display("FAIL b2b_ready[%0d]: got alu=%0b ld=%0b want accepted", i, bus0.alu_ready, bus0.ld_ready); end
         tick();
         if (bus0.wr_enable) got.push_back(bus0.wr_data);
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus0.wr_enable) got.push_back(bus0.wr_data);
      end
      checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL b2b_count: got %0d writes want %0d", got.size(), sent.size()); end
      for (int i = 0; i < sent.size() && i < got.size(); i++) begin
         checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %0h want %0h", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_bypass();
      bus0.byp_num_a = 5'd7; bus0.byp_num_b = 5'd8;
      bus0.alu_valid = 1'b1; bus0.alu_num = 5'd7; bus0.alu_data = 32'h11;
      #1;
      checks++; if (bus0.byp_hit_a !== 1'b0) begin errors++; $display("FAIL byp_incoming: got %0b want 0", bus0.byp_hit_a); end
      tick();
      bus0.alu_data = 32'h22;
      #1;
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b1, 32'h11}) begin errors++; $display("FAIL byp_first: got hit=%0b data=%0h want 1/11", bus0.byp_hit_a, bus0.byp_data_a); end
      tick();
      bus0.alu_valid = 1'b0;
      #1;
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b1, 32'h22}) begin errors++; $display("FAIL byp_both: got hit=%0b data=%0h want 1/22", bus0.byp_hit_a, bus0.byp_data_a); end
      checks++; if ({bus0.byp_hit_b, bus0.byp_data_b} !== {1'b0, 32'h0}) begin errors++; $display("FAIL byp_b_miss: got hit=%0b data=%0h want 0/0", bus0.byp_hit_b, bus0.byp_data_b); end
      bus0.byp_num_b = 5'd7;
      tick();
      checks++; if ({bus0.byp_hit_b, bus0.byp_data_b} !== {1'b1, 32'h22}) begin errors++; $display("FAIL byp_stage: got hit=%0b data=%0h want 1/22", bus0.byp_hit_b, bus0.byp_data_b); end
      tick();
      checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {1'b0, 32'h0}) begin errors++; $display("FAIL byp_done: got hit=%0b data=%0h want 0/0", bus0.byp_hit_a, bus0.byp_data_a); end
   endtask

   task automatic test_zero_drop();
      bus1.byp_num_a = 5'd0;
      bus1.alu_valid = 1'b1; bus1.alu_num = 5'd0; bus1.alu_data = 32'hFF;
      #1;
      checks++; if (bus1.alu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b want 1", bus1.alu_ready); end
      tick();
      bus1.alu_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if ({bus1.wr_enable, bus1.pending_cnt, bus1.byp_hit_a} !== {1'b0, PC_W'(0), 1'b0})
            begin errors++; $display("FAIL zero_dropped[%0d]: got en=%0b pend=%0d hit=%0b want 0/0/0", c, bus1.wr_enable, bus1.pending_cnt, bus1.byp_hit_a); end
         tick();
      end
      bus1.alu_valid = 1'b1; bus1.alu_num = 5'd2; bus1.alu_data = 32'h55;
      tick();
      bus1.alu_valid = 1'b0;
      tick();
      checks++; if ({bus1.wr_enable, bus1.wr_num, bus1.wr_data} !== {1'b1, 5'd2, 32'h55})
         begin errors++; $display("FAIL zero_nonzero_kept: got en=%0b num=%0d data=%0h want 1/2/55", bus1.wr_enable, bus1.wr_num, bus1.wr_data); end
      tick();
   endtask

   task automatic test_random();
      logic              eh_a, eh_b;
      logic [DATA_W-1:0] ed_a, ed_b;
      for (int c = 0; c < 300; c++) begin
         if (!(bus0.alu_valid && !m_acc_alu)) begin
            bus0.alu_valid = ($urandom_range(1) == 1);
            bus0.alu_num   = REG_NUM_W'($urandom_range(3));
            bus0.alu_data  = $urandom;
         end
         if (!(bus0.ld_valid && !m_acc_ld)) begin
            bus0.ld_valid = ($urandom_range(1) == 1);
            bus0.ld_num   = REG_NUM_W'($urandom_range(3));
            bus0.ld_data  = $urandom;
         end
         bus0.byp_num_a = REG_NUM_W'($urandom_range(3));
         bus0.byp_num_b = REG_NUM_W'($urandom_range(REG_FILE_SIZE - 1) % 5);
         #1;
         m_byp(bus0.byp_num_a, eh_a, ed_a);
         m_byp(bus0.byp_num_b, eh_b, ed_b);
         checks++; if (bus0.alu_ready !== (m_fifo.size() < DEPTH)) begin errors++; $display("FAIL rnd_alu_ready@%0d: got %0b", c, bus0.alu_ready); end
         checks++; if (bus0.ld_ready !== ((m_fifo.size() < DEPTH) && !bus0.alu_valid)) begin errors++; $display("FAIL rnd_ld_ready@%0d: got %0b", c, bus0.ld_ready); end
         checks++; if ({bus0.wr_enable, bus0.wr_num, bus0.wr_data} !== {m_wen, m_wnum, m_wdata})
            begin errors++; $display("FAIL rnd_write@%0d: got %0b/%0d/%0h want %0b/%0d/%0h", c, bus0.wr_enable, bus0.wr_num, bus0.wr_data, m_wen, m_wnum, m_wdata); end
         checks++; if ({bus0.byp_hit_a, bus0.byp_data_a} !== {eh_a, ed_a})
            begin errors++; $display("FAIL rnd_byp_a@%0d: got %0b/%0h want %0b/%0h", c, bus0.byp_hit_a, bus0.byp_data_a, eh_a, ed_a); end
         checks++; if ({bus0.byp_hit_b, bus0.byp_data_b} !== {eh_b, ed_b})
            begin errors++; $display("FAIL rnd_byp_b@%0d: got %0b/%0h want %0b/%0h", c, bus0.byp_hit_b, bus0.byp_data_b, eh_b, ed_b); end
         checks++; if (bus0.pending_cnt !== PC_W'(m_fifo.size() + int'(m_wen)))
            begin errors++; $display("FAIL rnd_pending@%0d: got %0d want %0d", c, bus0.pending_cnt, m_fifo.size() + int'(m_wen)); end
         checks++; if (bus0.empty !== (m_fifo.size() == 0 && !m_wen)) begin errors++; $display("FAIL rnd_empty@%0d: got %0b", c, bus0.empty); end
         tick();
      end
      idle_inputs();
      for (int c = 0; c < 3; c++) tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         bus0.alu_valid = 1'b1; bus0.alu_num = REG_NUM_W'(i + 9); bus0.alu_data = 32'hC0 + i;
         tick();
      end
      checks++; if ({bus0.wr_enable, bus0.pending_cnt} !== {1'b1, PC_W'(2)})
         begin errors++; $display("FAIL rstmid_before: got en=%0b pend=%0d want 1/2", bus0.wr_enable, bus0.pending_cnt); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus0.wr_enable, bus0.pending_cnt, bus0.empty} !== {1'b0, PC_W'(0), 1'b1})
         begin errors++; $display("FAIL rstmid_async: got en=%0b pend=%0d empty=%0b want 0/0/1", bus0.wr_enable, bus0.pending_cnt, bus0.empty); end
      idle_inputs();
      model_reset();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if ({bus0.wr_enable, bus0.empty} !== {1'b0, 1'b1})
            begin errors++; $display("FAIL rstmid_after[%0d]: got en=%0b empty=%0b want 0/1", c, bus0.wr_enable, bus0.empty); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_acc_alu = 1'b0;
      m_acc_ld  = 1'b0;
      test_reset();
      test_single_alu();
      test_alu_ld_priority();
      test_back_to_back();
      test_bypass();
      test_zero_drop();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
